// File: rtl/map_ram_port_arbiter_pkg.sv
// Shared types and constants for the map_RAM port-B arbiter.
// Holds the FSM state encoding, the map_RAM geometry and the requester indices.
// Imported by the interface, the round-robin picker and the arbiter top.
package map_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  localparam int MAP_ADDR_W = 5;    // 32 rows
  localparam int MAP_DATA_W = 160;  // 40 tiles x 4 bits
  localparam int OWNER_W    = 2;    // width of owner_id / rr_ptr

  localparam int REQ_SPRITE = 0;
  localparam int REQ_RELOAD = 1;
  localparam int REQ_SCAN   = 2;

endpackage

// File: rtl/map_ram_port_arbiter_if.sv
// Master-side bundle of the map_RAM port-B arbiter.
// Ports: req/addr_in/wrdata_in/wren_in from the masters (sliced per master),
// gnt/owner_id/busy/timeout_err back from the arbiter.
interface map_ram_port_arbiter_if
  import map_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = MAP_ADDR_W,
  parameter int DATA_W  = MAP_DATA_W
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr_in;
  logic [NUM_REQ*DATA_W-1:0] wrdata_in;
  logic [NUM_REQ-1:0]        wren_in;
  logic [NUM_REQ-1:0]        gnt;
  logic [OWNER_W-1:0]        owner_id;
  logic                      busy;
  logic                      timeout_err;

  modport master (
    output req, addr_in, wrdata_in, wren_in,
    input  gnt, owner_id, busy, timeout_err
  );

  modport slave (
    input  req, addr_in, wrdata_in, wren_in,
    output gnt, owner_id, busy, timeout_err
  );

endinterface

// File: rtl/map_ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible bit at or above rr_ptr, wrapping.
// Ports: eligible vector + rr_ptr in; one-hot winner, its index and a valid flag out.
// Pure logic, zero latency.
module rr_pick
  import map_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [OWNER_W-1:0] rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [OWNER_W-1:0] win_idx,
  output logic               win_vld
);

  logic [NUM_REQ-1:0] rot;
  int                 pos;
  int                 sum;

  always_comb begin
    // Rotate so that bit 0 of rot corresponds to requester rr_ptr.
    rot     = NUM_REQ'({eligible, eligible} >> rr_ptr);
    pos     = 0;
    win_vld = 1'b0;
    // Scan from the top down so the lowest set bit wins.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (rot[off]) begin
        pos     = off;
        win_vld = 1'b1;
      end
    end
    sum = int'(rr_ptr) + pos;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    win_idx = win_vld ? OWNER_W'(sum) : '0;
    winner  = win_vld ? (NUM_REQ'(1) << sum) : '0;
  end

endmodule

// File: rtl/map_ram_port_arbiter.sv
// Locks map_RAM port B to one master per transaction, round-robin, with a hold watchdog.
// Ports: CLOCK_50/reset, master bundle (bus), ram_addr/ram_data/ram_wren to address_b/data_b/wren_b.
// Grant one cycle after req; one dead TURN cycle between owners so q_b is never stale.
module map_ram_port_arbiter
  import map_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = MAP_ADDR_W,
  parameter int DATA_W   = MAP_DATA_W,
  parameter int MAX_HOLD = 64
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  map_ram_port_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_data,
  output logic                   ram_wren
);

  localparam int HOLD_W = $clog2(MAX_HOLD);

  arb_state_t          state, state_nxt;
  logic [NUM_REQ-1:0]  gnt_q, gnt_nxt;
  logic [NUM_REQ-1:0]  lockout, lock_nxt;
  logic [OWNER_W-1:0]  owner_q, owner_nxt;
  logic [OWNER_W-1:0]  rr_ptr, rr_nxt, next_ptr;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic                terr_q, terr_nxt;
  logic [ADDR_W-1:0]   addr_hold;

  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [OWNER_W-1:0]  pick_idx;
  logic                pick_vld;

  logic [ADDR_W-1:0]   own_addr;
  logic [DATA_W-1:0]   own_data;
  logic                own_wren;
  logic                own_req;

  // A master that timed out stays out of arbitration until it drops req once.
  assign eligible = bus.req & ~lockout;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .winner   (pick_onehot),
    .win_idx  (pick_idx),
    .win_vld  (pick_vld)
  );

  // Owner's slices; non-owner inputs never reach the RAM.
  always_comb begin
    own_addr = '0;
    own_data = '0;
    own_wren = 1'b0;
    own_req  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OWNER_W'(i)) begin
        own_addr = bus.addr_in[i*ADDR_W +: ADDR_W];
        own_data = bus.wrdata_in[i*DATA_W +: DATA_W];
        own_wren = bus.wren_in[i];
        own_req  = bus.req[i];
      end
    end
  end

  assign next_ptr = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);

  // Port B drive is decoded from registered state, so an async reset
  // kills the write strobe immediately.
  assign ram_wren = (state == OWN) && own_wren;
  assign ram_addr = (state == OWN) ? own_addr : addr_hold;
  assign ram_data = (state == OWN) ? own_data : '0;

  assign bus.gnt         = gnt_q;
  assign bus.owner_id    = owner_q;
  assign bus.busy        = (state == OWN);
  assign bus.timeout_err = terr_q;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    owner_nxt = owner_q;
    hold_nxt  = hold_cnt;
    rr_nxt    = rr_ptr;
    lock_nxt  = lockout & bus.req;
    terr_nxt  = 1'b0;
    case (state)
      OWN: begin
        hold_nxt = hold_cnt + HOLD_W'(1);
        if (!own_req) begin
          // Voluntary release wins over a coincident watchdog expiry.
          state_nxt = TURN;
          gnt_nxt   = '0;
          rr_nxt    = next_ptr;
        end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          state_nxt = TURN;
          gnt_nxt   = '0;
          rr_nxt    = next_ptr;
          terr_nxt  = 1'b1;
          lock_nxt  = lock_nxt | gnt_q;
        end
      end
      default: begin
        // IDLE and TURN arbitrate identically; TURN just never stays put.
        state_nxt = IDLE;
        gnt_nxt   = '0;
        if (pick_vld) begin
          state_nxt = OWN;
          gnt_nxt   = pick_onehot;
          owner_nxt = pick_idx;
          hold_nxt  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt_q     <= '0;
      lockout   <= '0;
      owner_q   <= OWNER_W'(REQ_SPRITE);
      rr_ptr    <= OWNER_W'(REQ_SPRITE);
      hold_cnt  <= '0;
      terr_q    <= 1'b0;
      addr_hold <= '0;
    end else begin
      state     <= state_nxt;
      gnt_q     <= gnt_nxt;
      lockout   <= lock_nxt;
      owner_q   <= owner_nxt;
      rr_ptr    <= rr_nxt;
      hold_cnt  <= hold_nxt;
      terr_q    <= terr_nxt;
      addr_hold <= ram_addr;
    end
  end

endmodule

// File: tb/tb_map_ram_port_arbiter.sv
// Directed bench for map_ram_port_arbiter with grant-order and RAM-write scoreboards.
module tb_map_ram_port_arbiter;
  import map_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = MAP_ADDR_W;
  localparam int DW = MAP_DATA_W;
  localparam int HOLD_LIMIT = 64;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          CLOCK_50 = 1'b0;
  logic          reset    = 1'b1;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wren;

  map_ram_port_arbiter_if bus ();

  map_ram_port_arbiter dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_wren (ram_wren)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int  errors = 0;
  int  checks = 0;
  wr_t exp_wr[$];
  int  exp_own[$];

  int own2, own0, terr_cnt, last2, terr_at, first0, e;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] pattern(input int i);
    return {5{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic cyc();
    @(negedge CLOCK_50);
  endtask

  task automatic set_master(input int i, input logic r, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic w);
    bus.req[i]               = r;
    bus.addr_in[i*AW +: AW]  = a;
    bus.wrdata_in[i*DW +: DW] = d;
    bus.wren_in[i]           = w;
  endtask

  task automatic clear_masters();
    bus.req       = '0;
    bus.addr_in   = '0;
    bus.wrdata_in = '0;
    bus.wren_in   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_masters();
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  // Bounded wait for any grant; an expired budget shows up as a failed check.
  task automatic wait_gnt(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLOCK_50);
      #1;
      if (|bus.gnt) seen = 1'b1;
    end
    check("gnt_wait", |bus.gnt, 1'b1);
  endtask

  // Any write strobe on port B must match the head of the expected-write queue.
  task automatic observe_write(input string tag);
    wr_t w;
    if (ram_wren) begin
      if (exp_wr.size() == 0) begin
        check({tag, "_unexpected"}, ram_wren, 1'b0);
      end else begin
        w = exp_wr.pop_front();
        check({tag, "_addr"}, ram_addr, w.addr);
        check({tag, "_data"}, ram_data, w.data);
      end
    end else begin
      check({tag, "_wren"}, ram_wren, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_masters();
    #1 reset = 1'b0;
    #2;
    // ---- reset state
    check("rst_gnt", bus.gnt, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_owner", bus.owner_id, 0);
    check("rst_terr", bus.timeout_err, 0);
    check("rst_wren", ram_wren, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", ram_data, 0);
    cyc();
    cyc();
    reset = 1'b1;

    // ---- T1: single master, grant latency, forwarding, release
    cyc();
    set_master(REQ_SPRITE, 1'b1, 5'd7, pattern(7), 1'b1);
    exp_wr.push_back('{addr: 5'd7, data: pattern(7)});
    exp_wr.push_back('{addr: 5'd7, data: pattern(7)});
    #1;
    check("t1_gnt_latency", bus.gnt, 0);
    check("t1_wren_idle", ram_wren, 0);
    cyc(); #1;
    check("t1_gnt", bus.gnt, 3'b001);
    check("t1_busy", bus.busy, 1);
    check("t1_owner", bus.owner_id, 0);
    observe_write("t1_w1");
    cyc();
    bus.req[0] = 1'b0;
    #1;
    check("t1_gnt_last", bus.gnt, 3'b001);
    observe_write("t1_w2");
    cyc(); #1;
    check("t1_turn_gnt", bus.gnt, 0);
    check("t1_turn_busy", bus.busy, 0);
    check("t1_turn_wren", ram_wren, 0);
    check("t1_turn_addr", ram_addr, 5'd7);
    check("t1_turn_data", ram_data, 0);
    bus.wren_in[0] = 1'b0;
    cyc(); #1;
    check("t1_sb_empty", exp_wr.size(), 0);

    // ---- T2: round robin 0,1,2,0 with one TURN between owners
    do_reset();
    cyc();
    for (int i = 0; i < N; i++) set_master(i, 1'b1, AW'(10 + i), pattern(10 + i), 1'b1);
    exp_own.push_back(REQ_SPRITE);
    exp_own.push_back(REQ_RELOAD);
    exp_own.push_back(REQ_SCAN);
    exp_own.push_back(REQ_SPRITE);
    wait_gnt(4);
    for (int k = 0; k < 4; k++) begin
      e = exp_own.pop_front();
      check("t2_gnt", bus.gnt, onehot(e));
      check("t2_owner", bus.owner_id, e);
      check("t2_addr", ram_addr, 10 + e);
      check("t2_wren", ram_wren, 1);
      cyc();
      cyc();
      cyc();
      if (k == 3) bus.req = '0;
      else        bus.req[e] = 1'b0;
      #1;
      check("t2_last_wren", ram_wren, 1);
      cyc(); #1;
      check("t2_turn_gnt", bus.gnt, 0);
      check("t2_turn_wren", ram_wren, 0);
      check("t2_turn_addr", ram_addr, 10 + e);
      if (k < 3) begin
        bus.req[e] = 1'b1;
        cyc(); #1;
      end
    end
    cyc(); #1;
    check("t2_idle_gnt", bus.gnt, 0);
    clear_masters();

    // ---- T3: non-owner writes are ignored
    cyc();
    set_master(REQ_RELOAD, 1'b1, 5'd11, pattern(11), 1'b0);
    wait_gnt(4);
    check("t3_gnt", bus.gnt, 3'b010);
    cyc();
    set_master(REQ_SPRITE, 1'b0, 5'd3, pattern(3), 1'b1);
    #1;
    check("t3_addr", ram_addr, 5'd11);
    check("t3_wren", ram_wren, 0);
    check("t3_data", ram_data, pattern(11));
    cyc(); #1;
    check("t3_wren2", ram_wren, 0);
    clear_masters();
    cyc();
    cyc();

    // ---- T4: watchdog on master 2, master 0 served meanwhile
    cyc();
    set_master(REQ_SCAN, 1'b1, 5'd12, pattern(12), 1'b0);
    own2 = 0; own0 = 0; terr_cnt = 0; last2 = -1; terr_at = -1; first0 = -1;
    for (int c = 1; c < 100; c++) begin
      @(negedge CLOCK_50);
      #1;
      if (bus.gnt[2]) begin own2++; last2 = c; end
      if (bus.timeout_err) begin terr_cnt++; terr_at = c; end
      if (bus.gnt[0]) begin
        own0++;
        if (first0 < 0) first0 = c;
        if (own0 == 3) bus.req[0] = 1'b0;
      end
      if (c == 10) set_master(REQ_SPRITE, 1'b1, 5'd13, pattern(13), 1'b0);
    end
    check("t4_owned_cycles", own2, HOLD_LIMIT);
    check("t4_terr_pulses", terr_cnt, 1);
    check("t4_terr_cycle", terr_at, last2 + 1);
    check("t4_m0_after_turn", first0, last2 + 2);
    check("t4_m0_owned", own0, 3);
    check("t4_locked_busy", bus.busy, 0);
    cyc();
    bus.req[2] = 1'b0;
    cyc();
    bus.req[2] = 1'b1;
    cyc(); #1;
    check("t4_regrant", bus.gnt, 3'b100);
    clear_masters();
    cyc();
    cyc();

    // ---- T5: async reset mid-OWN, rr_ptr back to 0
    cyc();
    set_master(REQ_RELOAD, 1'b1, 5'd1, pattern(1), 1'b0);
    wait_gnt(4);
    check("t5_pre_gnt", bus.gnt, 3'b010);
    cyc();
    bus.req[1] = 1'b0;
    cyc();
    cyc();
    set_master(REQ_SPRITE, 1'b1, 5'd5, pattern(5), 1'b1);
    wait_gnt(4);
    check("t5_own_gnt", bus.gnt, 3'b001);
    check("t5_own_wren", ram_wren, 1);
    cyc();
    #2 reset = 1'b0;
    #1;
    check("t5_rst_gnt", bus.gnt, 0);
    check("t5_rst_wren", ram_wren, 0);
    check("t5_rst_busy", bus.busy, 0);
    clear_masters();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    bus.req = 3'b110;
    cyc(); #1;
    check("t5_rr_gnt", bus.gnt, 3'b010);
    check("t5_rr_owner", bus.owner_id, 1);

    // ---- T6: final write on release, TURN, then the new owner
    bus.req = '0;
    cyc();
    cyc();
    cyc();
    set_master(REQ_SPRITE, 1'b1, 5'd20, pattern(20), 1'b1);
    exp_wr.push_back('{addr: 5'd20, data: pattern(20)});
    cyc(); #1;
    check("t6_gnt0", bus.gnt, 3'b001);
    observe_write("t6_w1");
    cyc();
    set_master(REQ_SPRITE, 1'b0, 5'd21, pattern(21), 1'b1);
    set_master(REQ_RELOAD, 1'b1, 5'd9, pattern(9), 1'b0);
    exp_wr.push_back('{addr: 5'd21, data: pattern(21)});
    #1;
    observe_write("t6_final");
    cyc(); #1;
    check("t6_turn_gnt", bus.gnt, 0);
    check("t6_turn_wren", ram_wren, 0);
    check("t6_turn_addr", ram_addr, 5'd21);
    cyc(); #1;
    check("t6_next_gnt", bus.gnt, 3'b010);
    check("t6_next_owner", bus.owner_id, 1);
    check("t6_sb_empty", exp_wr.size(), 0);
    clear_masters();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/map_ram_port_arbiter.md
Name: map_ram_port_arbiter

Overview:
- Shares port B of map_RAM (32 rows x 160 bits, 1-cycle read latency) between up to NUM_REQ multi-cycle masters.
- Masters: the sprite writer, the level-reload copier and the pellet-count scanner.
- Each master holds an exclusive lock for a whole transaction. Lock is granted round-robin, with a watchdog that revokes stuck owners.
- Sits between the masters and map_RAM; q_b fans out to all masters unmodified.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = sprite writer)
ADDR_W, 5, map RAM row address width
DATA_W, 160, map RAM row width (40 tiles x 4 bits)
MAX_HOLD, 64, max consecutive owned cycles before forced release

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-low reset
req  in  NUM_REQ  lock request per master; held high for the whole transaction
addr_in  in  NUM_REQ*ADDR_W  row address per master, slice i = [i*ADDR_W +: ADDR_W]
wrdata_in  in  NUM_REQ*DATA_W  write data per master, same slicing
wren_in  in  NUM_REQ  write enable per master
gnt  out  NUM_REQ  one-hot grant, registered
ram_addr  out  ADDR_W  to map_RAM address_b
ram_data  out  DATA_W  to map_RAM data_b
ram_wren  out  1  to map_RAM wren_b
owner_id  out  2  index of current owner; valid when busy=1
busy  out  1  1 while in OWN
timeout_err  out  1  1-cycle pulse on forced release

Behaviour:
- Reset (reset=0, async): state IDLE; gnt=0, busy=0, owner_id=0, timeout_err=0, ram_wren=0, ram_addr=0, ram_data=0; hold_cnt=0; rr_ptr=0; lockout=0.
- States: IDLE, OWN, TURN.
- IDLE:
  - Eligible set E = req & ~lockout.
  - If E!=0: pick the first set bit searching from rr_ptr upward, with wrap. Register gnt/owner_id and go to OWN.
  - Grant latency: gnt rises the cycle after req is first sampled high.
- OWN:
  - ram_addr/ram_data/ram_wren = owner's slices, combinational mux. Non-owner wren_in is ignored.
  - hold_cnt increments each cycle.
  - req[owner]=0 -> go to TURN. gnt drops on that same edge. The owner's wren in the cycle it drops req is still forwarded.
  - hold_cnt==MAX_HOLD-1 with req still high -> go to TURN, pulse timeout_err, set lockout[owner].
- TURN:
  - One dead cycle: ram_wren=0, ram_addr holds its last value, gnt=0.
  - Protects the 1-cycle read latency so the next owner never sees stale q_b.
  - rr_ptr = (owner+1) mod NUM_REQ.
  - Arbitration runs as in IDLE: if E!=0, go directly to OWN with the new grant; else go to IDLE.
- Outside OWN: ram_wren forced 0; ram_data=0; ram_addr holds its last value.
- Lockout: lockout[i] clears on the first cycle req[i]=0. A timed-out master must deassert req before it can re-win.
- Simultaneous events: a new req arriving in the same cycle the owner releases goes through TURN first, never back-to-back. The releasing master is excluded from that pick via rr_ptr ordering only.
- hold_cnt width: $clog2(MAX_HOLD). It is cleared on entry to OWN.
- Reset mid-transaction: grant is lost immediately. Masters must restart their FSMs; the sprite writer's reset is tied to the same net.

Decomposition:
- Package map_arb_pkg:
  - state enum {IDLE, OWN, TURN}
  - MAP_ADDR_W=5, MAP_DATA_W=160
  - requester index constants REQ_SPRITE=0, REQ_RELOAD=1, REQ_SCAN=2
- Sub-module rr_pick: combinational round-robin picker. Inputs eligible vector and rr_ptr; outputs one-hot winner, index and valid.

Test Plan:
- After reset, req=3'b001, addr_in[0]=5'd7, wren_in[0]=1 -> gnt=3'b001 one cycle later; ram_addr=7, ram_wren=1 while owned; busy=1, owner_id=0.
- req=3'b111 held, each master releasing after 4 owned cycles -> grant order 0,1,2,0. Exactly one TURN cycle between owners with ram_wren=0.
- Master 1 owns; master 0 asserts wren_in=1 with addr 5'd3 -> ram_addr stays at master 1's address; master 0's write never reaches the RAM.
- Master 2 holds req for 100 cycles -> gnt[2] drops after 64 owned cycles. timeout_err pulses once; master 2 is not regranted until it drops req for at least 1 cycle; master 0 requesting meanwhile is granted after TURN.
- reset=0 asserted asynchronously mid-OWN (between edges) -> gnt, ram_wren and busy go 0 immediately. After release, req=3'b110 -> master 1 is granted first (rr_ptr=0).
- Owner drops req in the same cycle master 1 raises req with wren_in[0]=1 in that cycle -> the final write is forwarded, then TURN (wren=0), then gnt=3'b010.
